int_divider: RTL

Iterative 64-bit integer divider for the execute stage, implementing LEGv8 `UDIV`/`SDIV`. It consumes `div_start`/`div_mode` from the decode control unit together with the Rn/Rm register operands. It returns `divider_done` with the quotient, which the datapath selects through `execute_result_loc = 2'b10`. Control holds the PC with `BCOND_OP_NOINC` while the divider runs, and commits the quotient on the `done` cycle.

---
 rtl/int_divider.sv | 110 +++++++++++
 1 files changed

// File: rtl/int_divider.sv
// Iterative restoring divider for LEGv8 UDIV/SDIV: one quotient bit per cycle,
// sign fix-up in a dedicated cycle, registered quotient/done outputs.
`timescale 1ns/1ps
module int_divider #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state and registered-output next values
  always_comb begin
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    done_d  = 1'b0;
    shifted = {rem_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d = mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          q_d   = (mode && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d = (mode && divisor[WIDTH-1])  ? -divisor  : divisor;
          rem_d = '0;
          cnt_d = CNT_W'(WIDTH);
          if (divisor == '0) begin
            quot_d = '0;
            done_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        quot_d = neg_q ? -q_q : q_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      dvs_q  <= dvs_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      done_q <= done_d;
    end
  end

  assign quotient = quot_q;
  assign done     = done_q;

endmodule
